mux2_4_arbiter: RTL
===================

Name: mux2_4_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 4-bit 2:1 selector datapath.
- Decides each cycle which source (A or B) drives the shared 4-bit bus, generates the mux select, and captures the selected nibble into a registered output stage with a valid/ready handshake.
- Limits consecutive grants per source (burst limit) for fairness; sits between two producer units and one downstream consumer.

Parameters:
- WIDTH, 4, data width of each source and of the output bus.
- MAX_BURST, 3, maximum consecutive grants to one source while the other is requesting (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  source A has valid data; held until ack_a.
- data_a  input  WIDTH  source A data; stable while req_a=1.
- ack_a  output  1  A's data captured this cycle (combinational).
- req_b  input  1  source B has valid data; held until ack_b.
- data_b  input  WIDTH  source B data; stable while req_b=1.
- ack_b  output  1  B's data captured this cycle (combinational).
- sel  output  1  mux select: 0 = A, 1 = B; reflects current/pending grant.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  out_data holds an untaken item.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- owner  output  2  00 none, 01 A, 10 B; current owner state.

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, sel=0, owner=00, burst_cnt=0, last_grant=B (so A wins first tie); ack_a = ack_b = 0. Data held at reset is discarded; no ack is issued for it.
- Slot free: load_en = !out_valid || out_ready. Arbitration only takes effect when load_en=1. Otherwise no ack is issued, and sel, owner and burst_cnt hold.
- Grant decision, evaluated combinationally when load_en=1:
  - Neither requesting: no grant. If out_ready consumed the item, out_valid goes 0. owner goes to 00. burst_cnt holds.
  - Only one requesting: grant it.
  - Both requesting, owner requested, and burst_cnt < MAX_BURST: grant the owner.
  - Both requesting, otherwise: grant the source that is not last_grant.
- On a grant to X:
  - ack_X=1 in the same cycle.
  - Next edge: out_data <= data_X with bit i -> bit i (no reordering), out_valid <= 1, last_grant <= X, owner <= X.
  - burst_cnt <= (X == previous owner) ? min(burst_cnt+1, MAX_BURST) : 1.
- Saturation: burst_cnt saturates at MAX_BURST and never wraps. A lone requester keeps the grant indefinitely; it yields on the first cycle the other source requests once burst_cnt == MAX_BURST.
- sel = 1 when the granted/owner source is B, else 0. In owner=00 with no grant, sel holds its last value.
- Latency: request to out_valid is 1 cycle when the slot is free. Back-to-back throughput is 1 item/cycle while out_ready=1.
- Backpressure:
  - out_ready=0 with out_valid=1: out_data and out_valid hold; no acks.
  - A requester held off keeps req and data stable.
- Simultaneous out_ready and new grant: the old item transfers and the new item loads on the same edge. There is no bubble.
- FSM (owner): IDLE(00) -> OWN_A / OWN_B on grant. OWN_X -> OWN_Y on a switch grant. Any state -> IDLE when load_en=1 and no request.
- Protocol checks (bench assertions):
  - ack_a and ack_b are never both 1.
  - ack_X implies req_X.
  - out_data is unchanged while out_valid && !out_ready.

Test Plan:
- Reset mid-transfer: out_valid=1, out_data=4'hC, out_ready=0, assert reset -> outputs immediately 0, owner=00, sel=0; after release, req_a with data_a=4'h5 gives out_data=4'h5 one cycle later.
- Single source stream: req_a held, data_a=1,2,3,4 updated on each ack_a, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles; owner=01; sel=0 throughout; burst_cnt saturates at 3 without wrap.
- Fairness with MAX_BURST=3: both req held, out_ready=1, data_a=4'hA, data_b=4'hB -> grant sequence A,A,A,B,B,B,A...; sel toggles accordingly; ack never both high.
- Bit order: data_b=4'b0001, req_b only -> out_data=4'b0001 (not 4'b1000); sel=1; owner=10.
- Backpressure: out_ready=0 for 3 cycles with both requesting -> out_data/out_valid frozen, no acks; out_ready=1 -> item transfers and the next grant loads on the same edge.
- Idle return: requests drop while out_ready=1 -> out_valid=0 next cycle, owner=00, sel holds last value.

Source files
------------

// File: rtl/mux2_4_arbiter_if.sv
// Handshake bundle between two producers, the arbiter and one consumer.
interface mux2_4_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             ack_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             ack_b;
  logic             sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       owner;

  // Producer/consumer side of the bundle.
  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  ack_a, ack_b, sel, out_data, out_valid, owner
  );

  // Arbiter side of the bundle.
  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output ack_a, ack_b, sel, out_data, out_valid, owner
  );
endinterface

// File: rtl/mux2_4_arbiter.sv
// Two-requester round-robin arbiter with burst limit feeding a registered
// single-entry output stage with valid/ready handshake.
module mux2_4_arbiter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 3
) (
  input logic             clk,
  input logic             reset,
  mux2_4_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  owner_e           owner_q, owner_d;
  src_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic load_en;
  logic owner_active;
  logic grant_a;
  logic grant_b;

  // Grant decision: only when the output slot is free; reset suppresses acks.
  always_comb begin
    load_en      = !out_valid_q || bus.out_ready;
    owner_active = (owner_q == OWN_A) || (owner_q == OWN_B);
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    if (load_en && !reset) begin
      if (bus.req_a && !bus.req_b) begin
        grant_a = 1'b1;
      end else if (bus.req_b && !bus.req_a) begin
        grant_b = 1'b1;
      end else if (bus.req_a && bus.req_b) begin
        if (owner_active && (burst_cnt_q < BURST_MAX)) begin
          // Owner keeps the bus until its burst allowance is used up.
          grant_a = (owner_q == OWN_A);
          grant_b = (owner_q == OWN_B);
        end else begin
          // Round-robin: hand the bus to whoever did not win last.
          grant_a = (last_grant_q == SRC_B);
          grant_b = (last_grant_q == SRC_A);
        end
      end
    end
  end

  // Next-state for owner, burst counter, select and output stage.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    sel_d        = sel_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    if (grant_a || grant_b) begin
      owner_d      = grant_b ? OWN_B : OWN_A;
      last_grant_d = grant_b ? SRC_B : SRC_A;
      sel_d        = grant_b;
      out_valid_d  = 1'b1;
      out_data_d   = grant_b ? bus.data_b : bus.data_a;
      if (owner_q == owner_d) begin
        // Same source again: count up, saturating at the burst limit.
        burst_cnt_d = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + CNT_W'(1) : BURST_MAX;
      end else begin
        burst_cnt_d = CNT_W'(1);
      end
    end else if (load_en) begin
      // Slot free and nobody asking: release ownership, retire any taken item.
      owner_d     = OWN_IDLE;
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= OWN_IDLE;
      last_grant_q <= SRC_B;
      burst_cnt_q  <= '0;
      sel_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign bus.ack_a     = grant_a;
  assign bus.ack_b     = grant_b;
  assign bus.sel       = sel_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.owner     = owner_q;

endmodule
